// File: rtl/serial_comparator_pkg.sv
// Shared definitions for the serial comparator.
//   state_t       : controller states (IDLE waits for start, CMP scans bits)
//   WIDTH_DEFAULT : default operand width
package serial_comparator_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_comparator_cmp_bit_cell.sv
// Single bit-pair decision cell for the serial comparator.
// Ports:
//   bit_a, bit_b : the operand bits at the current index
//   msb          : current index is the operand sign position
//   is_signed    : operands are two's complement
//   gt, lt, eq   : one-hot decision for this bit pair
module cmp_bit_cell (
  input  logic bit_a,
  input  logic bit_b,
  input  logic msb,
  input  logic is_signed,
  output logic gt,
  output logic lt,
  output logic eq
);

  logic inv;

  // At the sign bit of signed operands a set bit means negative, so the
  // sense of the decision flips.
  assign inv = msb & is_signed;

  always_comb begin
    eq = (bit_a == bit_b);
    gt = inv ? (~bit_a &  bit_b) : ( bit_a & ~bit_b);
    lt = inv ? ( bit_a & ~bit_b) : (~bit_a &  bit_b);
  end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator, MSB first, with early termination.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : request a comparison (accepted only while idle)
//   signed_mode : 1 = two's complement, 0 = unsigned (captured with start)
//   a, b        : operands (captured with start)
//   busy        : comparison in progress
//   done        : one-cycle pulse when g/l/e update
//   g, l, e     : a>b, a<b, a==b for the last completed comparison
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_t           state, next_state;
  logic [IW-1:0]    idx, next_idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sgn_r;
  logic             load;
  logic             resolve;
  logic             bit_gt, bit_lt, bit_eq;

  cmp_bit_cell u_cell (
    .bit_a     (a_r[idx]),
    .bit_b     (b_r[idx]),
    .msb       (idx == IDX_MSB),
    .is_signed (sgn_r),
    .gt        (bit_gt),
    .lt        (bit_lt),
    .eq        (bit_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    load       = 1'b0;
    resolve    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_idx   = IDX_MSB;
          next_state = CMP;
        end
      end
      CMP: begin
        // A differing pair or the last pair ends the scan.
        if (!bit_eq || idx == '0) begin
          resolve    = 1'b1;
          next_state = IDLE;
        end else begin
          next_idx = idx - IW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
      done  <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
    end else begin
      idx  <= next_idx;
      done <= resolve;
      if (load) begin
        a_r   <= a;
        b_r   <= b;
        sgn_r <= signed_mode;
      end
      if (resolve) begin
        g <= bit_gt;
        l <= bit_lt;
        e <= bit_eq;
      end
    end
  end

  assign busy = (state == CMP);

endmodule
